frame_stream_src: RTL

FRAME_STREAM_SRC -- requirements
Module: frame_stream_src

---
 rtl/frame_stream_src.sv | 139 +++++++++++++
 1 files changed

// File: rtl/frame_stream_src.sv
// Raster-order frame reader: fetches COL_NUM*ROW_NUM words from a 1-cycle-latency memory
// and streams them over valid/ready through a 2-entry skid FIFO with sof/eol/eof tags.
module frame_stream_src #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COL_NUM = 480,
  parameter int unsigned ROW_NUM = 272,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              ready,
  output logic              valid_out,
  output logic [WIDTH-1:0]  dout,
  output logic              sof,
  output logic              eol,
  output logic              eof
);

  localparam int unsigned PixNum = COL_NUM * ROW_NUM;
  localparam int unsigned ColW   = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int unsigned RowW   = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ColW-1:0]   col_q;
  logic [RowW-1:0]   row_q;
  logic              inflight_q;
  logic [2:0]        inflight_tag_q;
  logic [WIDTH-1:0]  fifo_data_q [2];
  logic [2:0]        fifo_tag_q  [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic       pop, rd_en, last_addr, clear_cnt, col_last, row_last;
  logic [2:0] level;
  logic [2:0] head_tag;

  assign valid_out = (count_q != 2'd0);
  assign pop       = valid_out & ready;
  assign head_tag  = fifo_tag_q[rd_ptr_q];
  assign last_addr = (addr_q == ADDR_W'(PixNum - 1));
  assign col_last  = (col_q == ColW'(COL_NUM - 1));
  assign row_last  = (row_q == RowW'(ROW_NUM - 1));
  assign clear_cnt = abort | ((state_q == StIdle) & start);

  // Committed occupancy after this cycle's pop; issue only if the FIFO has room for the return.
  assign level = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = (state_q == StRun) && (level < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (rd_en && last_addr) state_d = StDrain;
      StDrain: if (pop && head_tag[2]) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    busy      = (state_q == StRun) || (state_q == StDrain);
    done      = (state_q == StDone);
    mem_rd_en = rd_en;
    dout      = valid_out ? fifo_data_q[rd_ptr_q] : '0;
    sof       = valid_out & head_tag[0];
    eol       = valid_out & head_tag[1];
    eof       = valid_out & head_tag[2];
  end

  assign mem_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
    end else if (clear_cnt) begin
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_tag_q <= {col_last & row_last, col_last, (col_q == '0) & (row_q == '0)};
        addr_q         <= addr_q + 1'b1;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (abort) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= mem_rdata;
        fifo_tag_q[wr_ptr_q]  <= inflight_tag_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule
